ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Consumer end of the main-decoder control word.
- Takes the per-instruction control bits produced in the Decode (D) stage and carries them through the E, M and W pipeline registers.
- Computes the destination register and detects data hazards (load-use, branch-operand). Produces stall, bubble and forwarding selects for the 5-stage datapath.
- Also keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- WREG_D, M2REG_D, WMEM_D, ALUIMM_D, REGRT_D, JAL_D, BRANCH_D  in  1 each  decoder control bits for the instruction in D.
- ALUOP_D  in  3  decoder ALU op for the instruction in D.
- RS_D, RT_D, RD_D  in  5 each  instruction register fields in D.
- FLUSH_D  in  1  branch/jump taken; squash the instruction in D.
- WREG_E, M2REG_E, WMEM_E, ALUIMM_E  out  1 each  E-stage control.
- ALUOP_E  out  3  E-stage ALU op.
- RS_E, RT_E, WA_E  out  5 each  E-stage source and destination registers.
- WREG_M, M2REG_M, WMEM_M  out  1 each  M-stage control.
- WA_M  out  5  M-stage destination.
- WREG_W, M2REG_W  out  1 each  W-stage control.
- WA_W  out  5  W-stage destination.
- STALL_F, STALL_D  out  1 each  hold the PC and the F/D register.
- FWD_A_E, FWD_B_E  out  2 each  E operand selects: 00 regfile, 01 W result, 10 M ALU result.
- FWD_A_D, FWD_B_D  out  1 each  branch comparator forwards the M ALU result.
- STALL_CNT  out  CNT_W  number of stall cycles, saturating.

Behaviour:
- Reset (async, RST=1): every E/M/W register clears to 0, which is a bubble: no write, no memory access, ALUOP 000, addresses 0. STALL_CNT clears to 0. Forwarding and stall outputs are combinational, so they evaluate to 0 while the stages are empty.
- Destination in D: WA_D = 31 if JAL_D; else RT_D if REGRT_D; else RD_D. JAL takes priority.
- Latency: D inputs appear on the E outputs 1 edge later, M outputs 2 edges, W outputs 3 edges. M and W advance every cycle and never stall.
- Zero register: any WREG with destination 0 is treated as non-writing for hazard and forwarding purposes. The WREG_* outputs still pass through unchanged.
- Load-use stall: lwstall = M2REG_E & WA_E!=0 & (WA_E==RS_D | WA_E==RT_D).
- Branch stall: brstall = BRANCH_D & ((WREG_E & WA_E!=0 & WA_E∈{RS_D,RT_D}) | (M2REG_M & WA_M!=0 & WA_M∈{RS_D,RT_D})).
- Stall outputs: STALL_F = STALL_D = lwstall | brstall.
- Bubble insertion: when stalled or FLUSH_D=1, the E register loads a bubble (all control 0, ALUOP 000, addresses 0) instead of the D contents. Stall and FLUSH_D in the same cycle: a single bubble. FLUSH_D is not blocked by a stall.
- E forwarding, operand A (operand B is identical using RT_E):
  - 10 if WREG_M & WA_M!=0 & WA_M==RS_E;
  - else 01 if WREG_W & WA_W!=0 & WA_W==RS_E;
  - else 00.
  - M has priority over W.
- D forwarding: FWD_A_D = WREG_M & WA_M!=0 & WA_M==RS_D. FWD_B_D uses RT_D.
- ALUOP_D containing X (jump instructions) is registered as presented. No downstream logic depends on it when WREG=0.
- STALL_CNT: increments by 1 on each edge where STALL_D=1 and holds at all-ones. It is never cleared except by reset.
- Reset asserted mid-stall: everything returns to bubble immediately and the stall deasserts combinationally.

Decomposition:
- Shared package (cpu_pkg):
  - ALUOP codes: ADD 000, SUB 001, FUNC 010, OR 011, AND 100.
  - FWD codes: REGF 00, WB 01, MEM 10.
  - REG_RA = 5'd31, REG_ZERO = 5'd0.
  - Bubble constant for the stage control record.
- One sub-module, hazard_fwd: purely combinational. Produces stall, forwarding and zero-register qualification.
- ctrl_pipe owns the stage registers, the bubble mux and the counter.

Test Plan:
- Reset/latency: RST pulse, then addi with WREG_D=1, REGRT_D=1, RT_D=8 → WA_E=8 after 1 edge, WA_M=8 after 2, WA_W=8 and WREG_W=1 after 3. All outputs 0 during reset.
- Load-use: lw to $9 in E (M2REG_E=1, WA_E=9), then add with RS_D=9 in D → STALL_F=STALL_D=1 for exactly one cycle, E gets a bubble (WREG_E=0), STALL_CNT increments 0→1.
- Forwarding priority: add writes $10 in M and a different add writes $10 in W; E has RS_E=10, RT_E=10 → FWD_A_E=FWD_B_E=10. Remove the M writer → both become 01. Writer targets $0 → both 00.
- Branch hazard: beq RS_D=4 with add to $4 in E → brstall=1. Next cycle the add is in M → FWD_A_D=1, no stall. lw to $4 in M with beq in D → stall.
- JAL/flush: JAL_D=1, RD_D=5 → WA_E=31. FLUSH_D=1 together with a stall → a single bubble in E, no write or memory access propagates.
- Counter saturation: CNT_W=4, hold a stall condition for 20 cycles → STALL_CNT stops at 15. Assert RST mid-stall → STALL_CNT=0 and STALL_D=0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage pipeline control path: operation and
// forwarding codes, special register numbers and the per-stage control records.
package cpu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_FUNC = 3'b010,
    ALU_OR   = 3'b011,
    ALU_AND  = 3'b100
  } aluop_e;

  typedef enum logic [1:0] {
    FWD_REGF = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // ALU op is kept as a plain vector so jump encodings carrying X pass through untouched
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic [2:0] aluop;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
  } e_ctrl_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic [4:0] wa;
  } m_ctrl_t;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] wa;
  } w_ctrl_t;

  localparam e_ctrl_t E_BUBBLE = '0;
  localparam m_ctrl_t M_BUBBLE = '0;
  localparam w_ctrl_t W_BUBBLE = '0;

  // JAL links into $ra and wins over the rt/rd choice
  function automatic logic [4:0] dest_reg(input logic jal, input logic regrt,
                                          input logic [4:0] rt, input logic [4:0] rd);
    if (jal)        return REG_RA;
    else if (regrt) return rt;
    else            return rd;
  endfunction

  // A write to $0 is discarded by the register file, so it never creates a dependency
  function automatic logic real_write(input logic wreg, input logic [4:0] wa);
    return wreg && (wa != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_fwd.sv
// Combinational hazard detection and forwarding-select generation.
module hazard_fwd
  import cpu_pkg::*;
(
  input  logic       branch_d,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic       wreg_e,
  input  logic       m2reg_e,
  input  logic [4:0] wa_e,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic       wreg_m,
  input  logic       m2reg_m,
  input  logic [4:0] wa_m,
  input  logic       wreg_w,
  input  logic [4:0] wa_w,
  output logic       stall,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e,
  output logic       fwd_a_d,
  output logic       fwd_b_d
);

  logic wr_e, ld_e, wr_m, ld_m, wr_w;
  logic lwstall, brstall;

  // M result is newer than W, so it takes priority
  function automatic logic [1:0] e_sel(input logic [4:0] src, input logic m_ok,
                                       input logic [4:0] m_wa, input logic w_ok,
                                       input logic [4:0] w_wa);
    if (m_ok && (m_wa == src))      return FWD_MEM;
    else if (w_ok && (w_wa == src)) return FWD_WB;
    else                            return FWD_REGF;
  endfunction

  // Stall and forward decisions from the instructions currently in D, E, M and W
  always_comb begin
    wr_e    = real_write(wreg_e, wa_e);
    ld_e    = real_write(m2reg_e, wa_e);
    wr_m    = real_write(wreg_m, wa_m);
    ld_m    = real_write(m2reg_m, wa_m);
    wr_w    = real_write(wreg_w, wa_w);
    lwstall = ld_e && ((wa_e == rs_d) || (wa_e == rt_d));
    brstall = branch_d && ((wr_e && ((wa_e == rs_d) || (wa_e == rt_d))) ||
                           (ld_m && ((wa_m == rs_d) || (wa_m == rt_d))));
    stall   = lwstall || brstall;
    fwd_a_e = e_sel(rs_e, wr_m, wa_m, wr_w, wa_w);
    fwd_b_e = e_sel(rt_e, wr_m, wa_m, wr_w, wa_w);
    fwd_a_d = wr_m && (wa_m == rs_d);
    fwd_b_d = wr_m && (wa_m == rt_d);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control: carries decoder control from D through E, M and W, inserts
// bubbles on stall/flush, and counts stall cycles for performance debug.
module ctrl_pipe
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WREG_D,
  input  logic             M2REG_D,
  input  logic             WMEM_D,
  input  logic             ALUIMM_D,
  input  logic             REGRT_D,
  input  logic             JAL_D,
  input  logic             BRANCH_D,
  input  logic [2:0]       ALUOP_D,
  input  logic [4:0]       RS_D,
  input  logic [4:0]       RT_D,
  input  logic [4:0]       RD_D,
  input  logic             FLUSH_D,
  output logic             WREG_E,
  output logic             M2REG_E,
  output logic             WMEM_E,
  output logic             ALUIMM_E,
  output logic [2:0]       ALUOP_E,
  output logic [4:0]       RS_E,
  output logic [4:0]       RT_E,
  output logic [4:0]       WA_E,
  output logic             WREG_M,
  output logic             M2REG_M,
  output logic             WMEM_M,
  output logic [4:0]       WA_M,
  output logic             WREG_W,
  output logic             M2REG_W,
  output logic [4:0]       WA_W,
  output logic             STALL_F,
  output logic             STALL_D,
  output logic [1:0]       FWD_A_E,
  output logic [1:0]       FWD_B_E,
  output logic             FWD_A_D,
  output logic             FWD_B_D,
  output logic [CNT_W-1:0] STALL_CNT
);

  e_ctrl_t          e_d, e_p0;
  m_ctrl_t          m_p1;
  w_ctrl_t          w_p2;
  logic             stall;
  logic [CNT_W-1:0] cnt;

  // Pack the decoder outputs into the E-stage record
  always_comb begin
    e_d        = E_BUBBLE;
    e_d.wreg   = WREG_D;
    e_d.m2reg  = M2REG_D;
    e_d.wmem   = WMEM_D;
    e_d.aluimm = ALUIMM_D;
    e_d.aluop  = ALUOP_D;
    e_d.rs     = RS_D;
    e_d.rt     = RT_D;
    e_d.wa     = dest_reg(JAL_D, REGRT_D, RT_D, RD_D);
  end

  hazard_fwd u_hazard_fwd (
    .branch_d (BRANCH_D),
    .rs_d     (RS_D),
    .rt_d     (RT_D),
    .wreg_e   (e_p0.wreg),
    .m2reg_e  (e_p0.m2reg),
    .wa_e     (e_p0.wa),
    .rs_e     (e_p0.rs),
    .rt_e     (e_p0.rt),
    .wreg_m   (m_p1.wreg),
    .m2reg_m  (m_p1.m2reg),
    .wa_m     (m_p1.wa),
    .wreg_w   (w_p2.wreg),
    .wa_w     (w_p2.wa),
    .stall    (stall),
    .fwd_a_e  (FWD_A_E),
    .fwd_b_e  (FWD_B_E),
    .fwd_a_d  (FWD_A_D),
    .fwd_b_d  (FWD_B_D)
  );

  // D -> E: a stall or a flush (or both) loads one bubble
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                  e_p0 <= E_BUBBLE;
    else if (stall || FLUSH_D) e_p0 <= E_BUBBLE;
    else                      e_p0 <= e_d;
  end

  // E -> M -> W: these stages advance every cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_p1 <= M_BUBBLE;
      w_p2 <= W_BUBBLE;
    end else begin
      m_p1 <= '{wreg: e_p0.wreg, m2reg: e_p0.m2reg, wmem: e_p0.wmem, wa: e_p0.wa};
      w_p2 <= '{wreg: m_p1.wreg, m2reg: m_p1.m2reg, wa: m_p1.wa};
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      cnt <= '0;
    else if (stall && (cnt != '1)) cnt <= cnt + 1'b1;
  end

  assign WREG_E    = e_p0.wreg;
  assign M2REG_E   = e_p0.m2reg;
  assign WMEM_E    = e_p0.wmem;
  assign ALUIMM_E  = e_p0.aluimm;
  assign ALUOP_E   = e_p0.aluop;
  assign RS_E      = e_p0.rs;
  assign RT_E      = e_p0.rt;
  assign WA_E      = e_p0.wa;
  assign WREG_M    = m_p1.wreg;
  assign M2REG_M   = m_p1.m2reg;
  assign WMEM_M    = m_p1.wmem;
  assign WA_M      = m_p1.wa;
  assign WREG_W    = w_p2.wreg;
  assign M2REG_W   = w_p2.m2reg;
  assign WA_W      = w_p2.wa;
  assign STALL_F   = stall;
  assign STALL_D   = stall;
  assign STALL_CNT = cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: latency, load-use and branch stalls, forwarding
// priority, JAL destination, flush bubbles and counter saturation.
module tb_ctrl_pipe;

  localparam int CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             WREG_D, M2REG_D, WMEM_D, ALUIMM_D, REGRT_D, JAL_D, BRANCH_D;
  logic [2:0]       ALUOP_D;
  logic [4:0]       RS_D, RT_D, RD_D;
  logic             FLUSH_D;
  logic             WREG_E, M2REG_E, WMEM_E, ALUIMM_E;
  logic [2:0]       ALUOP_E;
  logic [4:0]       RS_E, RT_E, WA_E;
  logic             WREG_M, M2REG_M, WMEM_M;
  logic [4:0]       WA_M;
  logic             WREG_W, M2REG_W;
  logic [4:0]       WA_W;
  logic             STALL_F, STALL_D;
  logic [1:0]       FWD_A_E, FWD_B_E;
  logic             FWD_A_D, FWD_B_D;
  logic [CNT_W-1:0] STALL_CNT;

  int errors = 0;
  int checks = 0;

  ctrl_pipe #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .WREG_D(WREG_D), .M2REG_D(M2REG_D), .WMEM_D(WMEM_D), .ALUIMM_D(ALUIMM_D),
    .REGRT_D(REGRT_D), .JAL_D(JAL_D), .BRANCH_D(BRANCH_D), .ALUOP_D(ALUOP_D),
    .RS_D(RS_D), .RT_D(RT_D), .RD_D(RD_D), .FLUSH_D(FLUSH_D),
    .WREG_E(WREG_E), .M2REG_E(M2REG_E), .WMEM_E(WMEM_E), .ALUIMM_E(ALUIMM_E),
    .ALUOP_E(ALUOP_E), .RS_E(RS_E), .RT_E(RT_E), .WA_E(WA_E),
    .WREG_M(WREG_M), .M2REG_M(M2REG_M), .WMEM_M(WMEM_M), .WA_M(WA_M),
    .WREG_W(WREG_W), .M2REG_W(M2REG_W), .WA_W(WA_W),
    .STALL_F(STALL_F), .STALL_D(STALL_D),
    .FWD_A_E(FWD_A_E), .FWD_B_E(FWD_B_E), .FWD_A_D(FWD_A_D), .FWD_B_D(FWD_B_D),
    .STALL_CNT(STALL_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_d(input logic wreg, input logic m2reg, input logic wmem,
                       input logic regrt, input logic jal, input logic branch,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    WREG_D = wreg; M2REG_D = m2reg; WMEM_D = wmem; REGRT_D = regrt;
    JAL_D = jal; BRANCH_D = branch; RS_D = rs; RT_D = rt; RD_D = rd;
    ALUIMM_D = 1'b0; ALUOP_D = 3'b000; FLUSH_D = 1'b0;
    #1;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    nop();
    // reset
    #2 RST = 1'b1;
    #1;
    chk("rst_wreg_e", WREG_E, 0);
    chk("rst_wa_w", WA_W, 0);
    chk("rst_cnt", STALL_CNT, 0);
    chk("rst_stall", STALL_D, 0);
    chk("rst_fwd", {FWD_A_E, FWD_B_E, FWD_A_D, FWD_B_D}, 0);
    tick();
    #2 RST = 1'b0;
    tick();

    // latency: addi $8
    set_d(1, 0, 0, 1, 0, 0, 5'd1, 5'd8, 5'd3);
    ALUIMM_D = 1'b1; ALUOP_D = 3'b011;
    tick(); nop();
    chk("lat_wa_e", WA_E, 8);
    chk("lat_e_ctl", {WREG_E, ALUIMM_E, ALUOP_E}, 5'b1_1_011);
    tick();
    chk("lat_wa_m", WA_M, 8);
    chk("lat_wreg_m", WREG_M, 1);
    chk("lat_e_after", {WREG_E, WA_E}, 0);
    tick();
    chk("lat_wa_w", WA_W, 8);
    chk("lat_wreg_w", WREG_W, 1);

    // load-use: lw $9 then add $3,$9,$2
    set_d(1, 1, 0, 1, 0, 0, 5'd0, 5'd9, 5'd0);
    tick();
    set_d(1, 0, 0, 0, 0, 0, 5'd9, 5'd2, 5'd3);
    chk("lu_stall", {STALL_F, STALL_D}, 2'b11);
    tick();
    chk("lu_bubble", WREG_E, 0);
    chk("lu_cnt", STALL_CNT, 1);
    chk("lu_unstall", STALL_D, 0);
    chk("lu_lw_in_m", {WREG_M, M2REG_M, WA_M}, 7'b1_1_01001);
    tick(); nop();
    chk("lu_add_e", {WREG_E, RS_E, WA_E}, 11'b1_01001_00011);
    chk("lu_fwd_w", {FWD_A_E, FWD_B_E}, 4'b01_00);

    // forwarding: W and M both write $10
    set_d(1, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd10); tick();
    set_d(1, 0, 0, 0, 0, 0, 5'd3, 5'd4, 5'd10); tick();
    set_d(1, 0, 0, 0, 0, 0, 5'd10, 5'd10, 5'd11); tick(); nop();
    chk("fwd_mem", {FWD_A_E, FWD_B_E}, 4'b10_10);
    set_d(1, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd10); tick();
    nop(); tick();
    set_d(1, 0, 0, 0, 0, 0, 5'd10, 5'd10, 5'd11); tick(); nop();
    chk("fwd_wb", {FWD_A_E, FWD_B_E}, 4'b01_01);
    set_d(1, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0); tick();
    set_d(1, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0); tick();
    set_d(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd11); tick(); nop();
    chk("fwd_zero", {FWD_A_E, FWD_B_E}, 4'b00_00);

    // branch: add $4 in E, beq $4,$5 in D
    set_d(1, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd4); tick();
    set_d(0, 0, 0, 0, 0, 1, 5'd4, 5'd5, 5'd0);
    chk("br_stall_e", STALL_D, 1);
    tick();
    chk("br_unstall", STALL_D, 0);
    chk("br_fwd_d", {FWD_A_D, FWD_B_D}, 2'b10);
    chk("br_cnt", STALL_CNT, 2);
    tick(); nop();
    // lw $4 in M, beq in D
    set_d(1, 1, 0, 1, 0, 0, 5'd0, 5'd4, 5'd0); tick();
    nop(); tick();
    set_d(0, 0, 0, 0, 0, 1, 5'd5, 5'd4, 5'd0);
    chk("br_stall_lw_m", STALL_D, 1);
    chk("br_fwd_b_d", {FWD_A_D, FWD_B_D}, 2'b01);
    nop();
    chk("br_no_branch", STALL_D, 0);
    tick();

    // JAL: destination forced to $31
    set_d(1, 0, 0, 1, 1, 0, 5'd0, 5'd7, 5'd5); tick(); nop();
    chk("jal_wa_e", {WREG_E, WA_E}, 6'b1_11111);

    // flush together with a load-use stall
    set_d(1, 1, 0, 1, 0, 0, 5'd0, 5'd6, 5'd0); tick();
    set_d(1, 0, 1, 0, 0, 0, 5'd6, 5'd1, 5'd7);
    FLUSH_D = 1'b1;
    #1;
    chk("fl_stall", STALL_D, 1);
    tick(); nop();
    chk("fl_bubble_e", {WREG_E, M2REG_E, WMEM_E, ALUOP_E, WA_E}, 0);
    chk("fl_cnt", STALL_CNT, 3);
    tick();
    chk("fl_bubble_m", {WREG_M, WMEM_M, M2REG_M}, 0);
    // flush alone
    set_d(1, 0, 1, 0, 0, 0, 5'd1, 5'd2, 5'd7);
    FLUSH_D = 1'b1;
    tick(); nop();
    chk("fl_only", {WREG_E, WMEM_E, WA_E}, 0);
    tick();

    // saturation: repeated lw $9 reading $9 stalls every other cycle
    set_d(1, 1, 0, 1, 0, 0, 5'd9, 5'd9, 5'd0);
    for (int i = 0; i < 41; i++) tick();
    chk("sat_cnt", STALL_CNT, 15);
    chk("sat_stalling", STALL_D, 1);
    #2 RST = 1'b1;
    #1;
    chk("rst_mid_cnt", STALL_CNT, 0);
    chk("rst_mid_stall", STALL_D, 0);
    chk("rst_mid_wa_m", {WREG_M, WA_M}, 0);
    nop();
    tick();
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
